// File: rtl/usr_deser_if.sv
`default_nettype none
// ============================================================================
//  Module   : usr_deser_if
//  Brief    : Serial-in / word-out bundle for the usr deserializer. It carries
//             the bit stream, the valid/ready word port and the status flags.
//  Revision : 1.0 - initial release
// ============================================================================
interface usr_deser_if #(
    parameter int N = 8
);
    localparam int c_cnt_w = $clog2(N + 1);

    logic               sin_valid;
    logic               sin_bit;
    logic               sin_start;
    logic               sin_dir;
    logic               out_valid;
    logic               out_ready;
    logic [N-1:0]       out_data;
    logic               busy;
    logic [c_cnt_w-1:0] bit_cnt;
    logic               overrun;
    logic               frame_err;

    // Bit source and word consumer side.
    modport master (
        output sin_valid, sin_bit, sin_start, sin_dir, out_ready,
        input  out_valid, out_data, busy, bit_cnt, overrun, frame_err
    );

    // Deserializer side.
    modport slave (
        input  sin_valid, sin_bit, sin_start, sin_dir, out_ready,
        output out_valid, out_data, busy, bit_cnt, overrun, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/usr_deser.sv
`default_nettype none
// ============================================================================
//  Module   : usr_deser
//  Brief    : Reassembles the serial stream of a usr stage (MSB first or LSB
//             first) into N-bit words and offers them through a one-word
//             holding register on a valid/ready port.
//  Revision : 1.0 - initial release
// ============================================================================
module usr_deser #(
    parameter int N = 8
) (
    input  wire logic   clock,
    input  wire logic   reset,
    usr_deser_if.slave  bus
);
    localparam int                 c_cnt_w = $clog2(N + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(N - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N-1:0]       r_sreg;
    logic [N-1:0]       w_sreg_nxt;
    logic               r_dir;
    logic               w_dir_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               w_complete;
    logic               w_frame_hit;
    logic               w_slot_free;

    logic               r_out_valid;
    logic [N-1:0]       r_out_data;
    logic               r_overrun;
    logic               r_frame_err;

    // Direction 0 mirrors a left shift (first bit ends up as MSB), direction 1
    // mirrors a right shift (first bit ends up as LSB).
    function automatic logic [N-1:0] f_shift(input logic dir,
                                             input logic [N-1:0] s,
                                             input logic b);
        if (dir)
            return {b, s[N-1:1]};
        else
            return {s[N-2:0], b};
    endfunction

    // State register.
    always_ff @(posedge clock) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next state and collector next values; a start always restarts the word.
    always_comb begin
        w_state_nxt = r_state;
        w_sreg_nxt  = r_sreg;
        w_dir_nxt   = r_dir;
        w_cnt_nxt   = r_cnt;
        w_complete  = 1'b0;
        w_frame_hit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.sin_valid && bus.sin_start) begin
                    w_dir_nxt   = bus.sin_dir;
                    w_sreg_nxt  = f_shift(bus.sin_dir, r_sreg, bus.sin_bit);
                    w_cnt_nxt   = c_one;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bus.sin_valid) begin
                    if (bus.sin_start) begin
                        w_frame_hit = 1'b1;
                        w_dir_nxt   = bus.sin_dir;
                        w_sreg_nxt  = f_shift(bus.sin_dir, r_sreg, bus.sin_bit);
                        w_cnt_nxt   = c_one;
                    end else begin
                        w_sreg_nxt = f_shift(r_dir, r_sreg, bus.sin_bit);
                        if (r_cnt == c_last) begin
                            w_complete  = 1'b1;
                            w_cnt_nxt   = '0;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_cnt_nxt = r_cnt + c_one;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Collector datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sreg <= '0;
            r_dir  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_sreg <= w_sreg_nxt;
            r_dir  <= w_dir_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    // The slot can take a new word if empty or being popped this same cycle.
    assign w_slot_free = !r_out_valid || bus.out_ready;

    // Holding register, handshake and sticky error flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_complete && w_slot_free) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sreg_nxt;
            end else begin
                if (w_complete)
                    r_overrun <= 1'b1;
                if (r_out_valid && bus.out_ready)
                    r_out_valid <= 1'b0;
            end
            if (w_frame_hit)
                r_frame_err <= 1'b1;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.busy      = (r_state == S_SHIFT);
    assign bus.bit_cnt   = r_cnt;
    assign bus.overrun   = r_overrun;
    assign bus.frame_err = r_frame_err;
endmodule
`default_nettype wire

// File: tb/tb_usr_deser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_usr_deser
//  Brief    : Directed self-checking bench for usr_deser (N = 8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_usr_deser;
    localparam int N = 8;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    int   xfer_cnt;
    logic [N-1:0] last_xfer;

    usr_deser_if #(.N(N)) bus ();

    usr_deser #(.N(N)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Record every completed handshake.
    always @(posedge clock) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            xfer_cnt  <= xfer_cnt + 1;
            last_xfer <= bus.out_data;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset         = 1'b1;
        bus.sin_valid = 1'b0;
        bus.sin_start = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic send_bit(input logic st, input logic d, input logic b);
        bus.sin_valid = 1'b1;
        bus.sin_start = st;
        bus.sin_dir   = d;
        bus.sin_bit   = b;
        step();
        bus.sin_valid = 1'b0;
        bus.sin_start = 1'b0;
    endtask

    // Shifts a word out the way the usr stage does; optional idle gap between
    // bits and optional raise of out_ready just before the last bit.
    task automatic send_word(input logic [N-1:0] w, input logic d, input int gap,
                             input bit ready_last);
        for (int i = 0; i < N; i++) begin
            if (i == N - 1 && ready_last)
                bus.out_ready = 1'b1;
            send_bit(i == 0, d, d ? w[i] : w[N-1-i]);
            if (i != N - 1)
                for (int g = 0; g < gap; g++) step();
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_out valid=%b data=%h busy=%b expected 0/00/0",
                     bus.out_valid, bus.out_data, bus.busy);
        end
        checks++;
        if (bus.bit_cnt !== 4'd0 || bus.overrun !== 1'b0 || bus.frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags cnt=%0d ovr=%b ferr=%b expected 0/0/0",
                     bus.bit_cnt, bus.overrun, bus.frame_err);
        end
    endtask

    task automatic test_msb_first();
        int base;
        base = xfer_cnt;
        bus.out_ready = 1'b1;
        send_bit(1'b1, 1'b0, 1'b1);
        checks++;
        if (bus.busy !== 1'b1 || bus.bit_cnt !== 4'd1) begin
            errors++;
            $display("FAIL msb_first_bit busy=%b cnt=%0d expected 1/1", bus.busy, bus.bit_cnt);
        end
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b1);
        send_bit(1'b0, 1'b0, 1'b1);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.bit_cnt !== 4'd7) begin
            errors++;
            $display("FAIL msb_seven valid=%b cnt=%0d expected 0/7", bus.out_valid, bus.bit_cnt);
        end
        send_bit(1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hB2) begin
            errors++;
            $display("FAIL msb_word valid=%b data=%h expected 1/b2", bus.out_valid, bus.out_data);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.bit_cnt !== 4'd0) begin
            errors++;
            $display("FAIL msb_idle busy=%b cnt=%0d expected 0/0", bus.busy, bus.bit_cnt);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || xfer_cnt - base !== 1 || last_xfer !== 8'hB2) begin
            errors++;
            $display("FAIL msb_pop valid=%b xfers=%0d data=%h expected 0/1/b2",
                     bus.out_valid, xfer_cnt - base, last_xfer);
        end
    endtask

    task automatic test_lsb_gap();
        int base;
        base = xfer_cnt;
        bus.out_ready = 1'b1;
        send_word(8'hB2, 1'b1, 3, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hB2) begin
            errors++;
            $display("FAIL lsb_gap_word valid=%b data=%h expected 1/b2", bus.out_valid, bus.out_data);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || xfer_cnt - base !== 1) begin
            errors++;
            $display("FAIL lsb_gap_pop valid=%b xfers=%0d expected 0/1", bus.out_valid, xfer_cnt - base);
        end
    endtask

    task automatic test_stall();
        int base;
        base = xfer_cnt;
        bus.out_ready = 1'b0;
        send_word(8'h5A, 1'b0, 0, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h5A || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL stall_first valid=%b data=%h ovr=%b expected 1/5a/0",
                     bus.out_valid, bus.out_data, bus.overrun);
        end
        send_word(8'hC3, 1'b0, 0, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h5A || bus.overrun !== 1'b1) begin
            errors++;
            $display("FAIL stall_drop valid=%b data=%h ovr=%b expected 1/5a/1",
                     bus.out_valid, bus.out_data, bus.overrun);
        end
        bus.out_ready = 1'b1;
        step();
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || xfer_cnt - base !== 1 || last_xfer !== 8'h5A) begin
            errors++;
            $display("FAIL stall_pop valid=%b xfers=%0d data=%h expected 0/1/5a",
                     bus.out_valid, xfer_cnt - base, last_xfer);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        apply_reset();
        base = xfer_cnt;
        bus.out_ready = 1'b0;
        send_word(8'h11, 1'b0, 0, 1'b0);
        send_word(8'h22, 1'b0, 0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h22 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_refill valid=%b data=%h ovr=%b expected 1/22/0",
                     bus.out_valid, bus.out_data, bus.overrun);
        end
        checks++;
        if (xfer_cnt - base !== 1 || last_xfer !== 8'h11) begin
            errors++;
            $display("FAIL b2b_first xfers=%0d data=%h expected 1/11", xfer_cnt - base, last_xfer);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || xfer_cnt - base !== 2 || last_xfer !== 8'h22) begin
            errors++;
            $display("FAIL b2b_second valid=%b xfers=%0d data=%h expected 0/2/22",
                     bus.out_valid, xfer_cnt - base, last_xfer);
        end
        base = xfer_cnt;
        send_word(8'h33, 1'b1, 0, 1'b0);
        send_word(8'h44, 1'b0, 0, 1'b0);
        step();
        checks++;
        if (xfer_cnt - base !== 2 || last_xfer !== 8'h44 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ready xfers=%0d data=%h ovr=%b expected 2/44/0",
                     xfer_cnt - base, last_xfer, bus.overrun);
        end
    endtask

    task automatic test_restart();
        int base;
        base = xfer_cnt;
        bus.out_ready = 1'b1;
        send_bit(1'b1, 1'b0, 1'b1);
        send_bit(1'b0, 1'b0, 1'b1);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.busy !== 1'b1 || bus.bit_cnt !== 4'd4 || bus.frame_err !== 1'b0) begin
            errors++;
            $display("FAIL restart_partial busy=%b cnt=%0d ferr=%b expected 1/4/0",
                     bus.busy, bus.bit_cnt, bus.frame_err);
        end
        send_bit(1'b1, 1'b0, 1'b1);
        checks++;
        if (bus.frame_err !== 1'b1 || bus.bit_cnt !== 4'd1) begin
            errors++;
            $display("FAIL restart_flag ferr=%b cnt=%0d expected 1/1", bus.frame_err, bus.bit_cnt);
        end
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b1);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b1);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5) begin
            errors++;
            $display("FAIL restart_word valid=%b data=%h expected 1/a5", bus.out_valid, bus.out_data);
        end
        step();
        checks++;
        if (xfer_cnt - base !== 1 || last_xfer !== 8'hA5) begin
            errors++;
            $display("FAIL restart_count xfers=%0d data=%h expected 1/a5", xfer_cnt - base, last_xfer);
        end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        send_word(8'hFF, 1'b0, 0, 1'b0);
        send_bit(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.busy !== 1'b0 ||
            bus.bit_cnt !== 4'd0 || bus.frame_err !== 1'b0 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid valid=%b data=%h busy=%b cnt=%0d ferr=%b ovr=%b expected all 0",
                     bus.out_valid, bus.out_data, bus.busy, bus.bit_cnt, bus.frame_err, bus.overrun);
        end
        bus.out_ready = 1'b1;
        send_word(8'h3C, 1'b1, 0, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3C) begin
            errors++;
            $display("FAIL reset_mid_next valid=%b data=%h expected 1/3c", bus.out_valid, bus.out_data);
        end
        step();
    endtask

    task automatic test_random();
        logic [N-1:0] w;
        logic         d;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            w = N'($urandom);
            d = 1'($urandom);
            send_word(w, d, int'($urandom_range(0, 1)), 1'b0);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== w) begin
                errors++;
                $display("FAIL random_%0d dir=%b valid=%b data=%h expected 1/%h",
                         k, d, bus.out_valid, bus.out_data, w);
            end
        end
        step();
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        xfer_cnt      = 0;
        last_xfer     = '0;
        reset         = 1'b1;
        bus.sin_valid = 1'b0;
        bus.sin_bit   = 1'b0;
        bus.sin_start = 1'b0;
        bus.sin_dir   = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_msb_first();
        test_lsb_gap();
        test_stall();
        test_back_to_back();
        test_restart();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
